sin_osc_ctrl: RTL and testbench

SIN_OSC_CTRL -- requirements
Module: sin_osc_ctrl

---
 rtl/sin_osc_pkg.sv | 32 +++
 rtl/fpmult.sv | 49 ++++
 rtl/frac_to_float.sv | 16 +
 rtl/sin_osc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sin_osc_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sin_osc_pkg.sv
// Shared types and constants for the sine oscillator controller.
package sin_osc_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned FP_W    = 32;
    localparam int unsigned FRAC_W  = 31;
    localparam int unsigned SHIFT_W = 5;

    localparam logic [FP_W-1:0]   PI_OVER_2 = 32'h3FC9_0FDB;
    localparam logic [FP_W-1:0]   FP_ONE    = 32'h3F80_0000;
    localparam logic [FP_W-1:0]   FP_ZERO   = 32'h0000_0000;
    localparam logic [FRAC_W-1:0] AXIS_X    = 31'h4000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        NORM,
        MULT_RST,
        MULT_WAIT,
        ISSUE,
        SIN_HOLD,
        SIN_WAIT
    } state_e;

    // Fold a quadrant phase into a magnitude in [0, 2^30]; bit 30 of p selects mirroring.
    function automatic logic [FRAC_W-1:0] fold_frac(input logic [FRAC_W-1:0] p);
        logic [FRAC_W-1:0] f;
        f = {1'b0, p[29:0]};
        return p[30] ? (AXIS_X - f) : f;
    endfunction

endpackage

// File: rtl/fpmult.sv
// Multi-cycle single-precision multiplier shared across the codebase.
// Operands are assumed normal and non-zero; the mantissa is truncated.
// done_o drops while reset is high and rises two cycles after it is released.
module fpmult (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] product_o,
    output logic        done_o
);

    logic [47:0] mant_c;
    logic [7:0]  exp_c;
    logic [31:0] prod_c;
    logic        unused_mant_c;
    logic [1:0]  cnt_q;
    logic [31:0] product_q;
    logic        done_q;

    // Combinational product: sign, biased exponent sum, normalised mantissa.
    always_comb begin
        mant_c = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
        exp_c  = a_i[30:23] + b_i[30:23] - 8'd127 + 8'(mant_c[47]);
        prod_c = {a_i[31] ^ b_i[31], exp_c,
                  mant_c[47] ? mant_c[46:24] : mant_c[45:23]};
    end

    assign unused_mant_c = ^mant_c[22:0];

    // Count out the pipeline latency after reset, then hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 2'd0;
            product_q <= 32'h0;
            done_q    <= 1'b0;
        end else if (!done_q) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd1) begin
                product_q <= prod_c;
                done_q    <= 1'b1;
            end
        end
    end

    assign product_o = product_q;
    assign done_o    = done_q;

endmodule

// File: rtl/frac_to_float.sv
// Packs a normalised 31-bit fraction (bit 30 set) and its shift count into a float.
// Value represented is x / 2^30, so zero shifts gives exactly 1.0.
module frac_to_float
    import sin_osc_pkg::*;
(
    input  logic [FRAC_W-1:0]  x_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [FP_W-1:0]    fp_o
);

    logic unused_bits_c;

    assign fp_o          = {1'b0, 8'(8'd127 - 8'(shift_i)), x_i[29:7]};
    assign unused_bits_c = ^{x_i[30], x_i[6:0]};

endmodule

// File: rtl/sin_osc_ctrl.sv
// Phase-accumulating sine oscillator controller: folds the phase to [-pi/2, pi/2],
// converts it to a float angle, and sequences an external sine stage.
// Optional macro SIN_OSC_EXACT_AXIS_EN answers the 0 and +/-1 axis points
// directly without starting the sine stage.
module sin_osc_ctrl
    import sin_osc_pkg::*;
#(
    parameter int unsigned SIN_PREC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] freq_step,
    input  logic               sample_req,
    output logic               busy,
    output logic [FP_W-1:0]    theta,
    output logic [3:0]         prec_out,
    output logic               sin_start,
    input  logic               sin_done,
    input  logic [FP_W-1:0]    sin_result,
    output logic [FP_W-1:0]    sample,
    output logic               sample_valid
);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] p_q;
    logic [FRAC_W-1:0]  x_q;
    logic [SHIFT_W-1:0] s_q;
    logic               neg_q;
    logic               busy_q;
    logic               sin_start_q;
    logic               sample_valid_q;
    logic [FP_W-1:0]    theta_q;
    logic [FP_W-1:0]    sample_q;

    logic [FRAC_W-1:0]  fold_x_c;
    logic [FP_W-1:0]    norm_fp_c;
    logic [FP_W-1:0]    mult_prod_c;
    logic               mult_done_c;
    logic               mult_rst_c;
    logic               unused_prod_sign_c;

    assign fold_x_c           = fold_frac(p_q[30:0]);
    assign mult_rst_c         = reset | (state_q == MULT_RST);
    assign unused_prod_sign_c = mult_prod_c[31];

    // Normalised fraction to float.
    frac_to_float u_frac_to_float (
        .x_i     (x_q),
        .shift_i (s_q),
        .fp_o    (norm_fp_c)
    );

    // Scale the normalised magnitude by pi/2.
    fpmult u_fpmult (
        .clk       (clk),
        .reset     (mult_rst_c),
        .a_i       (norm_fp_c),
        .b_i       (PI_OVER_2),
        .product_o (mult_prod_c),
        .done_o    (mult_done_c)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            p_q            <= '0;
            x_q            <= '0;
            s_q            <= '0;
            neg_q          <= 1'b0;
            busy_q         <= 1'b0;
            sin_start_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            theta_q        <= FP_ZERO;
            sample_q       <= FP_ZERO;
        end else begin
            sin_start_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_req) begin
                        p_q     <= phase_q;
                        phase_q <= phase_q + freq_step;
                        busy_q  <= 1'b1;
                        state_q <= FOLD;
                    end
                end
                FOLD: begin
                    x_q   <= fold_x_c;
                    s_q   <= '0;
                    neg_q <= p_q[31];
`ifdef SIN_OSC_EXACT_AXIS_EN
                    if (fold_x_c == '0 || fold_x_c == AXIS_X) begin
                        sample_q       <= (fold_x_c == '0) ? FP_ZERO : {p_q[31], FP_ONE[30:0]};
                        sample_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else
`endif
                    if (fold_x_c == '0) begin
                        // Zero angle bypasses the multiplier and is always +0.0.
                        theta_q     <= FP_ZERO;
                        sin_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (fold_x_c[30]) begin
                        state_q <= MULT_RST;
                    end else begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    x_q <= x_q << 1;
                    s_q <= s_q + 5'd1;
                    if (x_q[29]) begin
                        state_q <= MULT_RST;
                    end
                end
                MULT_RST: begin
                    state_q <= MULT_WAIT;
                end
                MULT_WAIT: begin
                    if (mult_done_c) begin
                        theta_q     <= {neg_q, mult_prod_c[30:0]};
                        sin_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= SIN_HOLD;
                end
                SIN_HOLD: begin
                    // The sine stage's done may still be high from its previous result.
                    state_q <= SIN_WAIT;
                end
                SIN_WAIT: begin
                    if (sin_done) begin
                        sample_q       <= sin_result;
                        sample_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign theta        = theta_q;
    assign prec_out     = 4'(SIN_PREC);
    assign sin_start    = sin_start_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sin_osc_ctrl.sv
// Scoreboard bench for sin_osc_ctrl with a behavioural sine-stage model.
module tb_sin_osc_ctrl;

    localparam logic [31:0] SINE_KEY = 32'h5A5A_A5A5;
    localparam int          SINE_LAT = 3;
    localparam int          AX_NONE  = 0;
    localparam int          AX_ZERO  = 1;
    localparam int          AX_POS   = 2;
    localparam int          AX_NEG   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] freq_step = 32'h0;
    logic        sample_req = 1'b0;
    logic        busy;
    logic [31:0] theta;
    logic [3:0]  prec_out;
    logic        sin_start;
    logic        sin_done = 1'b1;
    logic [31:0] sin_result = 32'h0;
    logic [31:0] sample;
    logic        sample_valid;

    int n_checks = 0;
    int n_pass = 0;
    int valid_cnt = 0;
    int start_cnt = 0;
    int exp_start_cnt = 0;

    logic [31:0] exp_theta_q[$];
    logic [31:0] exp_sample_q[$];
    logic [31:0] cur_theta;
    bit          theta_live = 0;

    logic        sine_pend = 1'b0;
    int          sine_cnt = 0;
    logic [31:0] sine_th = 32'h0;

    sin_osc_ctrl #(.SIN_PREC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .freq_step    (freq_step),
        .sample_req   (sample_req),
        .busy         (busy),
        .theta        (theta),
        .prec_out     (prec_out),
        .sin_start    (sin_start),
        .sin_done     (sin_done),
        .sin_result   (sin_result),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Sine stage: done lingers one cycle after start, then falls for SINE_LAT cycles.
    always @(posedge clk) begin
        if (sin_start) begin
            sine_pend <= 1'b1;
            sine_th   <= theta;
        end else if (sine_pend) begin
            sine_pend <= 1'b0;
            sin_done  <= 1'b0;
            sine_cnt  <= SINE_LAT;
        end else if (!sin_done) begin
            if (sine_cnt == 1) begin
                sin_done   <= 1'b1;
                sin_result <= sine_th ^ SINE_KEY;
            end
            sine_cnt <= sine_cnt - 1;
        end
    end

    // Monitor: pop and compare whenever the DUT presents a start or a sample.
    always @(negedge clk) begin
        if (sin_start) begin
            start_cnt++;
            if (exp_theta_q.size() == 0) begin
                fail_event("unexpected sin_start");
            end else begin
                cur_theta = exp_theta_q.pop_front();
                theta_live = 1;
                check("theta_at_start", theta, cur_theta);
            end
        end
        if (sample_valid) begin
            valid_cnt++;
            if (exp_sample_q.size() == 0) begin
                fail_event("unexpected sample_valid");
            end else begin
                check("sample", sample, exp_sample_q.pop_front());
            end
            if (theta_live) begin
                check("theta_hold", theta, cur_theta);
                theta_live = 0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] th, input int ax);
`ifdef SIN_OSC_EXACT_AXIS_EN
        if (ax == AX_ZERO) begin exp_sample_q.push_back(32'h0000_0000); return; end
        if (ax == AX_POS)  begin exp_sample_q.push_back(32'h3F80_0000); return; end
        if (ax == AX_NEG)  begin exp_sample_q.push_back(32'hBF80_0000); return; end
`else
        if (ax < AX_NONE) return;
`endif
        exp_theta_q.push_back(th);
        exp_sample_q.push_back(th ^ SINE_KEY);
        exp_start_cnt++;
    endtask

    // One request: pulse sample_req, then wait (bounded) for sample_valid.
    task automatic do_req(input logic [31:0] fs, input logic [31:0] th, input int ax);
        int n;
        @(negedge clk);
        freq_step = fs;
        push_exp(th, ax);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
        n = 0;
        while (!sample_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sample_valid) fail_event("timeout waiting for sample_valid");
    endtask

    initial begin
        int n;
        int vc0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_theta", theta, 32'h0);
        check("reset_sample", sample, 32'h0);
        check("reset_sin_start", 32'(sin_start), 32'd0);
        check("reset_sample_valid", 32'(sample_valid), 32'd0);
        check("prec_out", 32'(prec_out), 32'd4);

        // Phase walk through the quadrant boundaries and mirrored points.
        do_req(32'h4000_0000, 32'h0000_0000, AX_ZERO);  // phase 0
        do_req(32'h4000_0000, 32'h3FC9_0FDB, AX_POS);   // phase 0x40000000
        do_req(32'h4000_0000, 32'h0000_0000, AX_ZERO);  // phase 0x80000000, +0.0
        do_req(32'h2000_0000, 32'hBFC9_0FDB, AX_NEG);   // phase 0xC0000000
        do_req(32'h4000_0000, 32'hBF49_0FDB, AX_NONE);  // phase 0xE0000000
        do_req(32'h0000_0100, 32'h3F49_0FDB, AX_NONE);  // phase 0x20000000
        do_req(32'h0000_0000, 32'h3F49_0FE1, AX_NONE);  // phase 0x20000100

        // sample_req held high: one conversion, phase advances once.
        @(negedge clk);
        freq_step = 32'h0000_0100;
        push_exp(32'h3F49_0FE1, AX_NONE);              // phase 0x20000100
        vc0 = valid_cnt;
        sample_req = 1'b1;
        n = 0;
        while (!sample_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        sample_req = 1'b0;
        if (!sample_valid) fail_event("timeout in held request");
        repeat (30) @(negedge clk);
        check("held_req_valid_count", 32'(valid_cnt - vc0), 32'd1);
        check("held_req_idle", 32'(busy), 32'd0);
        do_req(32'hE000_0E00, 32'h3F49_0FE7, AX_NONE);  // phase 0x20000200

        // Reset while normalising phase 0x00001000.
        @(negedge clk);
        freq_step = 32'h0000_0001;
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        vc0 = valid_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_theta", theta, 32'h0);
        check("abort_sample", sample, 32'h0);
        check("abort_sin_start", 32'(sin_start), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);

        do_req(32'h0000_0001, 32'h0000_0000, AX_ZERO);  // phase 0 after reset
        do_req(32'h3FFF_FFFE, 32'h30C9_0FDB, AX_NONE);  // phase 1, 30 shifts
        do_req(32'h0000_0000, 32'h3FC9_0FDA, AX_NONE);  // phase 0x3FFFFFFF, truncation

        repeat (10) @(negedge clk);
        check("sin_start_count", 32'(start_cnt), 32'(exp_start_cnt));
        check("pending_samples", 32'(exp_sample_q.size()), 32'd0);
        check("pending_thetas", 32'(exp_theta_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
